// File: rtl/bmu_req_arbiter.sv
// rtl/bmu_req_arbiter.sv - round-robin arbiter sharing one BMU between NUM_REQ requesters
// Registers the winner's operands into the BMU and returns its result tagged with the requester ID.
package rtl_pkg;

  typedef struct packed {
    logic land;
    logic lor;
    logic lxor;
    logic add;
    logic sub;
  } rtl_alu_pkt_t;

endpackage

module bmu_req_arbiter
  import rtl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int RES_LAT = 1,
  localparam int IDW = $clog2(NUM_REQ),
  localparam int CW  = $clog2(RES_LAT + 2)
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  logic                          arb_en,
  input  logic                          scan_mode,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  rtl_alu_pkt_t [NUM_REQ-1:0]    req_ap,
  input  logic [NUM_REQ-1:0]            req_csr_ren,
  input  logic [NUM_REQ-1:0][31:0]      req_csr_rddata,
  input  logic [NUM_REQ-1:0][31:0]      req_a,
  input  logic [NUM_REQ-1:0][31:0]      req_b,
  output logic                          bmu_scan_mode,
  output logic                          bmu_valid_in,
  output rtl_alu_pkt_t                  bmu_ap,
  output logic                          bmu_csr_ren_in,
  output logic [31:0]                   bmu_csr_rddata,
  output logic signed [31:0]            bmu_a_in,
  output logic [31:0]                   bmu_b_in,
  input  logic [31:0]                   bmu_result_ff,
  input  logic                          bmu_error,
  output logic                          rsp_valid,
  output logic [IDW-1:0]                rsp_id,
  output logic [31:0]                   rsp_result,
  output logic                          rsp_error,
  output logic [CW-1:0]                 inflight_cnt
);

  logic [IDW-1:0]             ptr;
  logic [IDW-1:0]             winner;
  logic                       accept;
  logic [RES_LAT:0]           tag_v;
  logic [RES_LAT:0][IDW-1:0]  tag_id;

  assign bmu_scan_mode = scan_mode;

  // Lowest distance above the last winner wins, so every requester is reached within NUM_REQ grants.
  always_comb begin : grant_scan
    int idx;
    idx       = 0;
    winner    = ptr;
    accept    = 1'b0;
    req_ready = '0;
    if (arb_en) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!accept && req_valid[IDW'(idx)]) begin
          accept = 1'b1;
          winner = IDW'(idx);
        end
      end
    end
    if (accept) req_ready = NUM_REQ'(1) << winner;
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      ptr            <= IDW'(NUM_REQ - 1);
      bmu_valid_in   <= 1'b0;
      bmu_ap         <= '0;
      bmu_csr_ren_in <= 1'b0;
      bmu_csr_rddata <= '0;
      bmu_a_in       <= '0;
      bmu_b_in       <= '0;
      tag_v          <= '0;
      tag_id         <= '0;
      inflight_cnt   <= '0;
    end else begin
      bmu_valid_in <= accept;
      if (accept) begin
        ptr            <= winner;
        bmu_ap         <= req_ap[winner];
        bmu_csr_ren_in <= req_csr_ren[winner];
        bmu_csr_rddata <= req_csr_rddata[winner];
        bmu_a_in       <= req_a[winner];
        bmu_b_in       <= req_b[winner];
      end
      // Stage 0 lines up with bmu_valid_in; stage RES_LAT with the BMU result.
      tag_v[0]  <= accept;
      tag_id[0] <= winner;
      for (int k = 1; k <= RES_LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
      inflight_cnt <= inflight_cnt + CW'(accept) - CW'(tag_v[RES_LAT]);
    end
  end

  assign rsp_valid  = tag_v[RES_LAT];
  assign rsp_id     = tag_id[RES_LAT];
  assign rsp_result = rsp_valid ? bmu_result_ff : '0;
  assign rsp_error  = rsp_valid & bmu_error;

endmodule

// File: tb/tb_bmu_req_arbiter.sv
// tb/tb_bmu_req_arbiter.sv - self-checking bench for bmu_req_arbiter
// Randomized stimulus compared against a queue-based model of issue order and response timing.
module tb_bmu_req_arbiter;
  import rtl_pkg::*;

  localparam int N   = 4;
  localparam int RL  = 1;
  localparam int IDW = 2;
  localparam int CW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_l;
  logic                 arb_en;
  logic                 scan_mode;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  rtl_alu_pkt_t [N-1:0] req_ap;
  logic [N-1:0]         req_csr_ren;
  logic [N-1:0][31:0]   req_csr_rddata;
  logic [N-1:0][31:0]   req_a;
  logic [N-1:0][31:0]   req_b;
  logic                 bmu_scan_mode;
  logic                 bmu_valid_in;
  rtl_alu_pkt_t         bmu_ap;
  logic                 bmu_csr_ren_in;
  logic [31:0]          bmu_csr_rddata;
  logic signed [31:0]   bmu_a_in;
  logic [31:0]          bmu_b_in;
  logic [31:0]          bmu_result_ff = '0;
  logic                 bmu_error = 1'b0;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [31:0]          rsp_result;
  logic                 rsp_error;
  logic [CW-1:0]        inflight_cnt;

  always #5 clk = ~clk;

  bmu_req_arbiter #(.NUM_REQ(N), .RES_LAT(RL)) dut (
    .clk(clk), .rst_l(rst_l), .arb_en(arb_en), .scan_mode(scan_mode),
    .req_valid(req_valid), .req_ready(req_ready), .req_ap(req_ap),
    .req_csr_ren(req_csr_ren), .req_csr_rddata(req_csr_rddata),
    .req_a(req_a), .req_b(req_b), .bmu_scan_mode(bmu_scan_mode),
    .bmu_valid_in(bmu_valid_in), .bmu_ap(bmu_ap), .bmu_csr_ren_in(bmu_csr_ren_in),
    .bmu_csr_rddata(bmu_csr_rddata), .bmu_a_in(bmu_a_in), .bmu_b_in(bmu_b_in),
    .bmu_result_ff(bmu_result_ff), .bmu_error(bmu_error), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_error(rsp_error),
    .inflight_cnt(inflight_cnt)
  );

  // Behavioural BMU: {error, result}; a packet with no operation selected is an error.
  function automatic logic [32:0] bmu_f(input rtl_alu_pkt_t ap, input logic [31:0] a, input logic [31:0] b);
    if (ap.land) return {1'b0, a & b};
    if (ap.lor)  return {1'b0, a | b};
    if (ap.lxor) return {1'b0, a ^ b};
    if (ap.add)  return {1'b0, a + b};
    if (ap.sub)  return {1'b0, a - b};
    return {1'b1, 32'h0};
  endfunction

  always @(posedge clk)
    if (bmu_valid_in) {bmu_error, bmu_result_ff} <= bmu_f(bmu_ap, bmu_a_in, bmu_b_in);

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        err;
    int          due;
    int          issued;
  } op_t;

  op_t          q[$];
  int           m_ptr;
  int           cyc;
  logic         m_bvalid;
  logic [31:0]  m_bmu_a;
  int           checks;
  int           failures;

  int           e_win;
  logic [N-1:0] e_ready;
  logic         e_rv;
  logic [IDW-1:0] e_id;
  logic [31:0]  e_res;
  logic         e_err;
  logic [CW-1:0] e_cnt;

  task automatic drive(input logic [N-1:0] v, input logic en);
    logic [4:0] op;
    for (int i = 0; i < N; i++) begin
      req_a[i]          = $urandom;
      req_b[i]          = $urandom;
      req_csr_rddata[i] = $urandom;
      req_csr_ren[i]    = 1'($urandom);
      op                = 5'b1 << $urandom_range(0, 4);
      if ($urandom_range(0, 7) == 0) op = 5'b0;
      req_ap[i]         = rtl_alu_pkt_t'(op);
    end
    req_valid = v;
    arb_en    = en;
    scan_mode = 1'($urandom);
  endtask

  task automatic eval();
    logic [N-1:0] one;
    int i;
    #1;
    one   = 1;
    e_win = -1;
    if (arb_en)
      for (int k = 1; k <= N; k++) begin
        i = (m_ptr + k) % N;
        if (e_win < 0 && req_valid[i]) e_win = i;
      end
    e_ready = (e_win >= 0) ? (one << e_win) : '0;
    e_rv = 1'b0; e_id = '0; e_res = '0; e_err = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e_rv  = 1'b1;
      e_id  = IDW'(q[0].id);
      e_res = q[0].res;
      e_err = q[0].err;
    end
    e_cnt = '0;
    foreach (q[j]) if (q[j].issued < cyc) e_cnt = e_cnt + 1'b1;
  endtask

  task automatic step();
    logic [32:0] f;
    if (e_rv) void'(q.pop_front());
    if (e_win >= 0) begin
      f = bmu_f(req_ap[e_win], req_a[e_win], req_b[e_win]);
      q.push_back('{e_win, f[31:0], f[32], cyc + 1 + RL, cyc});
      m_ptr   = e_win;
      m_bmu_a = req_a[e_win];
    end
    m_bvalid = (e_win >= 0);
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_l     = 1'b0;
    req_valid = '0;
    arb_en    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_l    = 1'b1;
    q.delete();
    m_ptr    = N - 1;
    m_bvalid = 1'b0;
    m_bmu_a  = '0;
    cyc++;
  endtask

  task automatic test_reset();
    do_reset();
    drive('0, 1'b1);
    eval();
    checks += 5;
    if (bmu_valid_in !== 1'b0) begin failures++; $display("FAIL reset_bmu_valid got=%b exp=0", bmu_valid_in); end
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    if (inflight_cnt !== '0) begin failures++; $display("FAIL reset_inflight got=%0d exp=0", inflight_cnt); end
    if (bmu_a_in !== '0) begin failures++; $display("FAIL reset_bmu_a got=%h exp=0", bmu_a_in); end
    if (req_ready !== '0) begin failures++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    step();
  endtask

  task automatic test_single();
    do_reset();
    drive(4'b0001, 1'b1);
    req_a[0] = 32'h0000_00F0; req_b[0] = 32'h0000_000F; req_ap[0] = rtl_alu_pkt_t'(5'b10000);
    eval();
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    step();
    drive('0, 1'b1);
    eval();
    checks += 2;
    if (bmu_valid_in !== 1'b1) begin failures++; $display("FAIL single_bmu_valid got=%b exp=1", bmu_valid_in); end
    if (bmu_a_in !== 32'h0000_00F0) begin failures++; $display("FAIL single_bmu_a got=%h exp=000000f0", bmu_a_in); end
    step();
    drive('0, 1'b1);
    eval();
    checks += 4;
    if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
    if (rsp_id !== 2'd0) begin failures++; $display("FAIL single_rsp_id got=%0d exp=0", rsp_id); end
    if (rsp_result !== 32'h0) begin failures++; $display("FAIL single_rsp_result got=%h exp=0", rsp_result); end
    if (rsp_error !== 1'b0) begin failures++; $display("FAIL single_rsp_error got=%b exp=0", rsp_error); end
    step();
    drive('0, 1'b1);
    eval();
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_rsp_once got=%b exp=0", rsp_valid); end
    step();
  endtask

  task automatic test_rr_all();
    logic [N-1:0] want;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      drive(4'b1111, 1'b1);
      eval();
      want = 4'b0001 << (k % 4);
      checks += 2;
      if (req_ready !== want) begin failures++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, req_ready, want); end
      if (rsp_result !== e_res) begin failures++; $display("FAIL rr_result k=%0d got=%h exp=%h", k, rsp_result, e_res); end
      if (k >= 2) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== IDW'((k - 2) % 4))
          begin failures++; $display("FAIL rr_rsp k=%0d got=%b/%0d exp=1/%0d", k, rsp_valid, rsp_id, (k - 2) % 4); end
      end
      step();
    end
  endtask

  task automatic test_single_hold();
    int peak;
    int grants;
    peak = 0;
    grants = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive((k < 5) ? 4'b0100 : 4'b0000, 1'b1);
      eval();
      if (req_ready === 4'b0100) grants++;
      if (int'(inflight_cnt) > peak) peak = int'(inflight_cnt);
      checks++;
      if (inflight_cnt !== e_cnt) begin failures++; $display("FAIL hold_inflight k=%0d got=%0d exp=%0d", k, inflight_cnt, e_cnt); end
      step();
    end
    checks += 2;
    if (grants !== 5) begin failures++; $display("FAIL hold_grants got=%0d exp=5", grants); end
    if (peak !== 2) begin failures++; $display("FAIL hold_peak got=%0d exp=2", peak); end
  endtask

  task automatic test_arb_en();
    do_reset();
    for (int k = 0; k < 2; k++) begin drive(4'b1111, 1'b1); eval(); step(); end
    for (int k = 0; k < 3; k++) begin
      drive(4'b1111, 1'b0);
      eval();
      checks += 4;
      if (req_ready !== '0) begin failures++; $display("FAIL en_ready k=%0d got=%b exp=0", k, req_ready); end
      if (bmu_valid_in !== (k == 0)) begin failures++; $display("FAIL en_bmu_valid k=%0d got=%b exp=%b", k, bmu_valid_in, k == 0); end
      if (rsp_valid !== (k < 2)) begin failures++; $display("FAIL en_rsp_valid k=%0d got=%b exp=%b", k, rsp_valid, k < 2); end
      if (rsp_valid && rsp_id !== IDW'(k)) begin failures++; $display("FAIL en_rsp_id k=%0d got=%0d exp=%0d", k, rsp_id, k); end
      step();
    end
    drive(4'b1111, 1'b1);
    eval();
    checks++;
    if (req_ready !== 4'b0100) begin failures++; $display("FAIL en_resume got=%b exp=0100", req_ready); end
    step();
  endtask

  task automatic test_reset_inflight();
    do_reset();
    for (int k = 0; k < 2; k++) begin drive(4'b1111, 1'b1); eval(); step(); end
    checks++;
    if (inflight_cnt !== 2'd2) begin failures++; $display("FAIL rst_pre_inflight got=%0d exp=2", inflight_cnt); end
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive('0, 1'b1);
      eval();
      checks += 2;
      if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp k=%0d got=%b exp=0", k, rsp_valid); end
      if (inflight_cnt !== '0) begin failures++; $display("FAIL rst_inflight k=%0d got=%0d exp=0", k, inflight_cnt); end
      step();
    end
    drive(4'b1111, 1'b1);
    eval();
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL rst_next_grant got=%b exp=0001", req_ready); end
    step();
  endtask

  task automatic test_error();
    do_reset();
    drive(4'b1000, 1'b1);
    req_ap[3] = rtl_alu_pkt_t'(5'b0);
    eval();
    checks++;
    if (req_ready !== 4'b1000) begin failures++; $display("FAIL err_ready got=%b exp=1000", req_ready); end
    step();
    drive(4'b1000, 1'b1);
    req_ap[3] = rtl_alu_pkt_t'(5'b00010);
    eval();
    step();
    drive('0, 1'b1);
    eval();
    checks++;
    if ({rsp_valid, rsp_id, rsp_error} !== {1'b1, 2'd3, 1'b1})
      begin failures++; $display("FAIL err_rsp got=%b/%0d/%b exp=1/3/1", rsp_valid, rsp_id, rsp_error); end
    step();
    drive('0, 1'b1);
    eval();
    checks++;
    if ({rsp_valid, rsp_id, rsp_error} !== {1'b1, 2'd3, 1'b0})
      begin failures++; $display("FAIL err_next got=%b/%0d/%b exp=1/3/0", rsp_valid, rsp_id, rsp_error); end
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      drive(N'($urandom), $urandom_range(0, 7) != 0);
      eval();
      checks += 7;
      if (req_ready !== e_ready) begin failures++; $display("FAIL rnd_ready k=%0d got=%b exp=%b", k, req_ready, e_ready); end
      if (rsp_valid !== e_rv) begin failures++; $display("FAIL rnd_rsp_valid k=%0d got=%b exp=%b", k, rsp_valid, e_rv); end
      if (e_rv && rsp_id !== e_id) begin failures++; $display("FAIL rnd_rsp_id k=%0d got=%0d exp=%0d", k, rsp_id, e_id); end
      if (rsp_result !== e_res) begin failures++; $display("FAIL rnd_result k=%0d got=%h exp=%h", k, rsp_result, e_res); end
      if (rsp_error !== e_err) begin failures++; $display("FAIL rnd_error k=%0d got=%b exp=%b", k, rsp_error, e_err); end
      if (inflight_cnt !== e_cnt) begin failures++; $display("FAIL rnd_inflight k=%0d got=%0d exp=%0d", k, inflight_cnt, e_cnt); end
      if (bmu_scan_mode !== scan_mode) begin failures++; $display("FAIL rnd_scan k=%0d got=%b exp=%b", k, bmu_scan_mode, scan_mode); end
      checks++;
      if (bmu_valid_in !== m_bvalid || (m_bvalid && bmu_a_in !== m_bmu_a))
        begin failures++; $display("FAIL rnd_bmu k=%0d got=%b/%h exp=%b/%h", k, bmu_valid_in, bmu_a_in, m_bvalid, m_bmu_a); end
      step();
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    rst_l     = 1'b0;
    arb_en    = 1'b0;
    scan_mode = 1'b0;
    req_valid = '0;
    req_ap    = '0;
    req_csr_ren = '0;
    req_csr_rddata = '0;
    req_a     = '0;
    req_b     = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_rr_all();
    test_single_hold();
    test_arb_en();
    test_reset_inflight();
    test_error();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
